// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle passed from the raster generator to the video controller.
interface vga_timing_gen_if;
  logic hsync_n;
  logic vsync_n;
  logic blank_n;
  logic end_of_line;
  logic end_of_frame;

  // Producer side: the timing generator.
  modport master (
    output hsync_n,
    output vsync_n,
    output blank_n,
    output end_of_line,
    output end_of_frame
  );

  // Consumer side: the framebuffer video controller.
  modport slave (
    input hsync_n,
    input vsync_n,
    input blank_n,
    input end_of_line,
    input end_of_frame
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator. Counts pixel clocks into (hcnt, vcnt) and
// registers sync/blank/position outputs that describe the previous cycle's counters,
// plus a completed-frame counter and a sticky vblank interrupt.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    irq_ack_i,
  vga_timing_gen_if.master        timing_o,
  output logic [10:0]             x_o,
  output logic [9:0]              y_o,
  output logic [15:0]             frame_cnt_o,
  output logic                    vblank_irq_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HActW    = 11'(H_ACTIVE);
  localparam logic [10:0] HsStart  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VActW    = 10'(V_ACTIVE);
  localparam logic [9:0]  VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hsync_n_q, hsync_n_d;
  logic        vsync_n_q, vsync_n_d;
  logic        blank_n_q, blank_n_d;
  logic        eol_q, eol_d;
  logic        eof_q, eof_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        irq_q, irq_d;

  logic h_last;
  logic v_last;

  assign h_last = (hcnt_q == HLast);
  assign v_last = (vcnt_q == VLast);

  // Next-state for counters, decoded timing outputs, frame counter and irq flag.
  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    x_d         = '0;
    y_d         = '0;
    hsync_n_d   = 1'b1;
    vsync_n_d   = 1'b1;
    blank_n_d   = 1'b0;
    eol_d       = 1'b0;
    eof_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    irq_d       = irq_q;

    if (!en_i) begin
      // Park at the origin; outputs fall back to idle values.
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      x_d       = hcnt_q;
      y_d       = vcnt_q;
      blank_n_d = (hcnt_q < HActW) && (vcnt_q < VActW);
      hsync_n_d = !((hcnt_q >= HsStart) && (hcnt_q < HsEnd));
      vsync_n_d = !((vcnt_q >= VsStart) && (vcnt_q < VsEnd));
      eol_d     = h_last;
      eof_d     = h_last && v_last;

      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
    end

    // The frame counts once its end_of_frame pulse has been presented.
    if (eof_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Setting takes priority over a coincident acknowledge.
    if (en_i && (hcnt_q == '0) && (vcnt_q == VActW)) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hsync_n_q   <= 1'b1;
      vsync_n_q   <= 1'b1;
      blank_n_q   <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hsync_n_q   <= hsync_n_d;
      vsync_n_q   <= vsync_n_d;
      blank_n_q   <= blank_n_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      frame_cnt_q <= frame_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign timing_o.hsync_n      = hsync_n_q;
  assign timing_o.vsync_n      = vsync_n_q;
  assign timing_o.blank_n      = blank_n_q;
  assign timing_o.end_of_line  = eol_q;
  assign timing_o.end_of_frame = eof_q;
  assign x_o                   = x_q;
  assign y_o                   = y_q;
  assign frame_cnt_o           = frame_cnt_q;
  assign vblank_irq_o          = irq_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
// A predictor turns each clock's inputs into the expected outputs from a linear pixel
// index; a monitor pops and compares one entry per cycle on the falling edge.
module tb_vga_timing_gen;

  localparam int HA = 20;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic        eol;
    logic        eof;
    logic [10:0] x;
    logic [9:0]  y;
    logic [15:0] fc;
    logic        irq;
  } obs_t;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic        irq_ack_i;
  logic [10:0] x_o;
  logic [9:0]  y_o;
  logic [15:0] frame_cnt_o;
  logic        vblank_irq_o;

  vga_timing_gen_if timing ();

  vga_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .irq_ack_i    (irq_ack_i),
    .timing_o     (timing),
    .x_o          (x_o),
    .y_o          (y_o),
    .frame_cnt_o  (frame_cnt_o),
    .vblank_irq_o (vblank_irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t sb_q[$];

  // Reference model state: next pixel index within the frame, frames done, irq flag.
  int   m_pix = 0;
  int   m_fc  = 0;
  logic m_irq = 1'b0;
  int   px, py;
  obs_t e;

  // Predictor: one expected observation per clock edge outside reset.
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_pix = 0;
      m_fc  = 0;
      m_irq = 1'b0;
    end else begin
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (en_i) begin
        px    = m_pix % HT;
        py    = m_pix / HT;
        e.x   = 11'(px);
        e.y   = 10'(py);
        e.bl  = (px < HA) && (py < VA);
        e.hs  = !((px >= HA + HF) && (px < HA + HF + HS));
        e.vs  = !((py >= VA + VF) && (py < VA + VF + VS));
        e.eol = (px == HT - 1);
        e.eof = (m_pix == FRAME - 1);
        if (m_pix == VA * HT) m_irq = 1'b1;
        else if (irq_ack_i) m_irq = 1'b0;
        m_pix = (m_pix + 1) % FRAME;
      end else begin
        if (irq_ack_i) m_irq = 1'b0;
        m_pix = 0;
      end
      e.fc  = 16'(m_fc);
      e.irq = m_irq;
      if (e.eof) m_fc = (m_fc + 1) % 65536;
      sb_q.push_back(e);
    end
  end

  obs_t act, exp_o;

  // Monitor: compare whatever the DUT presents against the oldest prediction.
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      exp_o = sb_q.pop_front();
      act = {timing.hsync_n, timing.vsync_n, timing.blank_n, timing.end_of_line,
             timing.end_of_frame, x_o, y_o, frame_cnt_o, vblank_irq_o};
      n_cmp++;
      if (act !== exp_o) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t act hs=%b vs=%b bl=%b eol=%b eof=%b x=%0d y=%0d fc=%0d irq=%b req hs=%b vs=%b bl=%b eol=%b eof=%b x=%0d y=%0d fc=%0d irq=%b",
                 $time, act.hs, act.vs, act.bl, act.eol, act.eof, act.x, act.y, act.fc,
                 act.irq, exp_o.hs, exp_o.vs, exp_o.bl, exp_o.eol, exp_o.eof, exp_o.x,
                 exp_o.y, exp_o.fc, exp_o.irq);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] req);
    n_cmp++;
    if (actual !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, req);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hsync_n"}, 32'(timing.hsync_n), 32'd1);
    chk({tag, "_vsync_n"}, 32'(timing.vsync_n), 32'd1);
    chk({tag, "_blank_n"}, 32'(timing.blank_n), 32'd0);
    chk({tag, "_eol"}, 32'(timing.end_of_line), 32'd0);
    chk({tag, "_eof"}, 32'(timing.end_of_frame), 32'd0);
    chk({tag, "_x"}, 32'(x_o), 32'd0);
    chk({tag, "_y"}, 32'(y_o), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'd0);
    chk({tag, "_irq"}, 32'(vblank_irq_o), 32'd0);
  endtask

  int n;

  initial begin
    rst_i     = 1'b1;
    en_i      = 1'b0;
    irq_ack_i = 1'b0;
    repeat (3) step();
    check_idle("reset");
    rst_i = 1'b0;
    en_i  = 1'b1;

    // IRQ: ack 10 clocks after it rises.
    n = 0;
    while (!m_irq && n < 2 * FRAME) begin step(); n++; end
    if (n >= 2 * FRAME) timeout("irq_rise");
    repeat (10) step();
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
    step();
    chk("irq_acked", 32'(vblank_irq_o), 32'd0);

    // Ack coinciding with the set cycle of the next frame: set wins.
    n = 0;
    while (m_pix != VA * HT && n < 2 * FRAME) begin step(); n++; end
    if (n >= 2 * FRAME) timeout("irq_set_cycle");
    irq_ack_i = 1'b1;
    step();
    irq_ack_i = 1'b0;
    step();
    chk("irq_set_wins", 32'(vblank_irq_o), 32'd1);

    // Run until two more frames complete.
    n = 0;
    while (m_fc < 3 && n < 3 * FRAME) begin step(); n++; end
    if (n >= 3 * FRAME) timeout("frames_done");
    step();
    chk("frame_cnt_3", 32'(frame_cnt_o), 32'd3);

    // Disable mid-frame, then re-enable for a full frame.
    n = 0;
    while (m_pix != 4 * HT + 10 && n < 2 * FRAME) begin step(); n++; end
    if (n >= 2 * FRAME) timeout("disable_point");
    en_i = 1'b0;
    step();
    chk("disabled_x", 32'(x_o), 32'd0);
    chk("disabled_blank_n", 32'(timing.blank_n), 32'd0);
    chk("disabled_frame_cnt", 32'(frame_cnt_o), 32'd3);
    repeat (5) step();
    en_i = 1'b1;
    repeat (FRAME + 40) step();

    // Randomized enable and acknowledge traffic.
    for (int c = 0; c < 4000; c++) begin
      if (en_i && $urandom_range(199) == 0) en_i = 1'b0;
      else if (!en_i && $urandom_range(9) == 0) en_i = 1'b1;
      irq_ack_i = ($urandom_range(29) == 0);
      step();
    end
    irq_ack_i = 1'b0;
    en_i      = 1'b1;
    repeat (FRAME) step();

    // Asynchronous reset mid-line, away from any clock edge.
    n = 0;
    while (m_pix != VA * HT + 12 && n < 2 * FRAME) begin step(); n++; end
    if (n >= 2 * FRAME) timeout("async_reset_point");
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 check_idle("async_reset");
    repeat (2) step();
    rst_i = 1'b0;
    repeat (FRAME + 20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
